// File: rtl/led_pwm_bank_pkg.sv
// Package for the LED PWM bank.
// Purpose: shared types and helpers for led_pwm_bank, its config interface
// and its per-channel slices.
//   led_mode_t : 2-bit channel mode (OFF / ON / PWM / BLINK)
//   chw()      : channel-select width for a given channel count (minimum 1)
package led_pkg;

  typedef logic [1:0] led_mode_t;

  localparam led_mode_t MODE_OFF   = 2'b00;
  localparam led_mode_t MODE_ON    = 2'b01;
  localparam led_mode_t MODE_PWM   = 2'b10;
  localparam led_mode_t MODE_BLINK = 2'b11;

  function automatic int chw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_bank_if.sv
// Configuration write port of the LED PWM bank (valid/ready).
// Parameters: NCH (channel count), PWM_W (duty width).
// Signals:
//   cfg_valid  master->slave  write request
//   cfg_ready  slave->master  write can be accepted (combinational on cfg_ch)
//   cfg_ch     master->slave  target channel, chw(NCH) bits
//   cfg_mode   master->slave  led_mode_t
//   cfg_duty   master->slave  duty value, PWM_W bits
interface led_pwm_bank_if #(
  parameter int NCH   = 4,
  parameter int PWM_W = 8
);
  import led_pkg::*;

  localparam int CHW = chw(NCH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CHW-1:0]   cfg_ch;
  led_mode_t        cfg_mode;
  logic [PWM_W-1:0] cfg_duty;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_duty,
    output cfg_ready
  );

endinterface

// File: rtl/led_pwm_chan.sv
// One LED channel of the PWM bank.
// Holds the shadow (written) and active (displayed) mode/duty, the pending
// flag that blocks further writes until the next PWM period boundary, the
// duty-to-brightness mapping, the compare, and the registered LED output.
// Build option: LED_GAMMA_EN selects a square-law duty mapping; without it
// the duty is used linearly.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wr          accepted write for this channel (one cycle)
//   wr_mode     mode to load into the shadow register
//   wr_duty     duty to load into the shadow register
//   wrap        PWM period boundary (last tick of the period)
//   pwm_cnt     shared PWM counter
//   blink_on    shared blink phase
//   pending     shadow holds a setting not yet applied
//   led         registered LED drive, active high
module led_pwm_chan
  import led_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  led_mode_t        wr_mode,
  input  logic [PWM_W-1:0] wr_duty,
  input  logic             wrap,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             blink_on,
  output logic             pending,
  output logic             led
);

  led_mode_t        shadow_mode_p0;
  logic [PWM_W-1:0] shadow_duty_p0;
  led_mode_t        act_mode_p0;
  logic [PWM_W-1:0] act_duty_p0;
  logic             pend_p0;
  logic             led_p1;

  logic             apply;
  led_mode_t        cur_mode;
  logic [PWM_W-1:0] cur_duty;
  logic [PWM_W-1:0] eff_duty;
  logic             cmp;
  logic             led_next;

`ifdef LED_GAMMA_EN
  // Square-law brightness: upper half of duty*duty. Full scale is pinned so
  // the brightest setting stays at 2^PWM_W-1 ticks on.
  function automatic logic [PWM_W-1:0] gamma(input logic [PWM_W-1:0] d);
    logic [2*PWM_W-1:0] prod;
    prod = {{PWM_W{1'b0}}, d} * {{PWM_W{1'b0}}, d};
    if (&d) return d;
    return prod[2*PWM_W-1:PWM_W];
  endfunction
`else
  function automatic logic [PWM_W-1:0] gamma(input logic [PWM_W-1:0] d);
    return d;
  endfunction
`endif

  // On the wrap cycle the pending shadow is forwarded straight into the
  // output decision, so the new setting shows on led right after the wrap.
  assign apply    = wrap & pend_p0;
  assign cur_mode = apply ? shadow_mode_p0 : act_mode_p0;
  assign cur_duty = apply ? shadow_duty_p0 : act_duty_p0;
  assign eff_duty = gamma(cur_duty);
  assign cmp      = (pwm_cnt < eff_duty);

  always_comb begin
    led_next = 1'b0;
    case (cur_mode)
      MODE_OFF:   led_next = 1'b0;
      MODE_ON:    led_next = 1'b1;
      MODE_PWM:   led_next = cmp;
      MODE_BLINK: led_next = cmp & blink_on;
      default:    led_next = 1'b0;
    endcase
  end

  // p0: shadow/active settings and pending flag; p1: LED output register.
  // A write is only accepted while pend_p0 is clear, so apply and wr never
  // coincide; a write on the wrap cycle waits for the following wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_mode_p0 <= MODE_OFF;
      shadow_duty_p0 <= '0;
      act_mode_p0    <= MODE_OFF;
      act_duty_p0    <= '0;
      pend_p0        <= 1'b0;
      led_p1         <= 1'b0;
    end else begin
      if (apply) begin
        act_mode_p0 <= shadow_mode_p0;
        act_duty_p0 <= shadow_duty_p0;
        pend_p0     <= 1'b0;
      end
      if (wr) begin
        shadow_mode_p0 <= wr_mode;
        shadow_duty_p0 <= wr_duty;
        pend_p0        <= 1'b1;
      end
      led_p1 <= led_next;
    end
  end

  assign pending = pend_p0;
  assign led     = led_p1;

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel LED driver: OFF / ON / PWM-dimmed / blinking-PWM per LED.
// Owns the prescaler, PWM and blink counters and the write decode; each LED
// is an led_pwm_chan slice. Duty/mode writes are double-buffered and take
// effect only at PWM period boundaries.
// Build option: LED_GAMMA_EN (square-law duty mapping inside each channel).
// Parameters: NCH channels (1..16), PWM_W duty bits (period 2^PWM_W ticks),
//   PRESC clocks per tick (>=1), BLINK_W blink counter bits.
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   cfg            led_pwm_bank_if.slave write port (valid/ready)
//   led            NCH registered LED drives, active high
//   period_strobe  one-cycle pulse in the cycle the PWM counter shows 0
module led_pwm_bank
  import led_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int PWM_W   = 8,
  parameter int PRESC   = 12,
  parameter int BLINK_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  led_pwm_bank_if.slave  cfg,
  output logic [NCH-1:0] led,
  output logic           period_strobe
);

  localparam int CHW = chw(NCH);
  localparam int PSW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PSW-1:0]     presc_cnt_p0;
  logic [PWM_W-1:0]   pwm_cnt_p0;
  logic [BLINK_W-1:0] blink_cnt_p0;
  logic               strobe_p1;

  logic               tick;
  logic               wrap;
  logic               blink_on;
  logic [NCH-1:0]     pending;
  logic [NCH-1:0]     wr;

  // With PRESC=1 the count sits at 0 and tick is high every cycle.
  assign tick     = (presc_cnt_p0 == PSW'(PRESC - 1));
  assign wrap     = tick & (&pwm_cnt_p0);
  assign blink_on = blink_cnt_p0[BLINK_W-1];

  // p0: timebase counters; p1: period strobe (registered wrap).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_p0 <= '0;
      pwm_cnt_p0   <= '0;
      blink_cnt_p0 <= '0;
      strobe_p1    <= 1'b0;
    end else begin
      presc_cnt_p0 <= tick ? '0 : presc_cnt_p0 + PSW'(1);
      if (tick) pwm_cnt_p0 <= pwm_cnt_p0 + PWM_W'(1);
      if (wrap) blink_cnt_p0 <= blink_cnt_p0 + BLINK_W'(1);
      strobe_p1 <= wrap;
    end
  end

  assign period_strobe = strobe_p1;

  // Out-of-range channels match nothing, so they stay ready and any write
  // to them is accepted and dropped.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg.cfg_ch == CHW'(i)) cfg.cfg_ready = ~pending[i];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign wr[g] = cfg.cfg_valid & cfg.cfg_ready & (cfg.cfg_ch == CHW'(g));

    led_pwm_chan #(
      .PWM_W (PWM_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (wr[g]),
      .wr_mode  (cfg.cfg_mode),
      .wr_duty  (cfg.cfg_duty),
      .wrap     (wrap),
      .pwm_cnt  (pwm_cnt_p0),
      .blink_on (blink_on),
      .pending  (pending[g]),
      .led      (led[g])
    );
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Bench for led_pwm_bank (NCH=4, PWM_W=4, PRESC=2, BLINK_W=2: 32-clk period).
// Stimulus pushes the expected per-period LED on-counts into a scoreboard;
// a monitor accumulates led per period and compares at each period_strobe.
// A second instance with NCH=3 exercises the out-of-range channel path.
module tb_led_pwm_bank;
  import led_pkg::*;

`ifdef LED_GAMMA_EN
  localparam int D4 = 2;   // duty 4 -> eff 1 -> 2 clk
  localparam int D8 = 8;   // duty 8 -> eff 4 -> 8 clk
`else
  localparam int D4 = 8;
  localparam int D8 = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] led;
  logic       period_strobe;
  logic [2:0] led3;
  logic       strobe3;

  always #5 clk = ~clk;

  led_pwm_bank_if #(.NCH(4), .PWM_W(4)) cfg ();
  led_pwm_bank_if #(.NCH(3), .PWM_W(4)) cfg3 ();

  led_pwm_bank #(.NCH(4), .PWM_W(4), .PRESC(2), .BLINK_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg           (cfg),
    .led           (led),
    .period_strobe (period_strobe)
  );

  led_pwm_bank #(.NCH(3), .PWM_W(4), .PRESC(2), .BLINK_W(2)) dut3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg           (cfg3),
    .led           (led3),
    .period_strobe (strobe3)
  );

  typedef struct {
    int win;
    int c0;
    int c1;
    int c2;
    int c3;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cur_win = 0;
  int   cnt[4]  = '{0, 0, 0, 0};

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic push_win(input int w, input int a, input int b, input int c, input int d);
    exp_t e;
    e.win = w; e.c0 = a; e.c1 = b; e.c2 = c; e.c3 = d;
    sb.push_back(e);
  endtask

  // Monitor: window k spans strobe k up to the cycle before strobe k+1.
  always @(negedge clk) begin
    exp_t e;
    int   ev[4];
    if (rst_n === 1'b1) begin
      if (period_strobe === 1'b1) begin
        while (sb.size() > 0 && sb[0].win <= cur_win) begin
          e = sb.pop_front();
          if (e.win < cur_win) begin
            checks++;
            errors++;
            $display("FAIL window %0d: expectation queued too late (now %0d)", e.win, cur_win);
          end else begin
            ev = '{e.c0, e.c1, e.c2, e.c3};
            for (int i = 0; i < 4; i++) begin
              checks++;
              if (cnt[i] != ev[i]) begin
                errors++;
                $display("FAIL win%0d_led%0d: on for %0d clk, expected %0d", e.win, i, cnt[i], ev[i]);
              end
            end
          end
        end
        cur_win++;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
      end
      for (int i = 0; i < 4; i++) cnt[i] += int'(led[i]);
    end
  end

  task automatic ready_of(input logic [1:0] ch, output int r);
    cfg.cfg_ch = ch;
    #1;
    r = int'(cfg.cfg_ready);
  endtask

  // Called mid-cycle; returns 1 ns after the edge that completed the transfer.
  task automatic cfg_write(input logic [1:0] ch, input led_mode_t mode,
                           input logic [3:0] duty, output int stall);
    stall = 0;
    cfg.cfg_ch    = ch;
    cfg.cfg_mode  = mode;
    cfg.cfg_duty  = duty;
    cfg.cfg_valid = 1'b1;
    forever begin
      #1;
      if (cfg.cfg_ready) begin
        @(posedge clk);
        break;
      end
      @(posedge clk);
      stall++;
      if (stall > 200) begin
        check("write_timeout", stall, 0);
        break;
      end
    end
    #1;
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic wait_strobe();
    int k;
    for (k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (period_strobe) break;
    end
    if (k == 100) check("strobe_timeout", k, 0);
  endtask

  initial begin
    int n, r, stall, bad;

    cfg.cfg_valid  = 1'b0;
    cfg.cfg_ch     = '0;
    cfg.cfg_mode   = MODE_OFF;
    cfg.cfg_duty   = '0;
    cfg3.cfg_valid = 1'b0;
    cfg3.cfg_ch    = '0;
    cfg3.cfg_mode  = MODE_OFF;
    cfg3.cfg_duty  = '0;

    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        check("reset_led", int'(led), 0);
        check("reset_led3", int'(led3), 0);
        check("reset_ready", int'(cfg.cfg_ready), 1);
        check("reset_strobe", int'(period_strobe), 0);
      end
      if (period_strobe) begin
        n = k;
        break;
      end
    end
    check("first_strobe_latency", n, 32);

    // Window 1: ch1 PWM duty 4; applies at the end of window 1.
    cfg_write(2'd1, MODE_PWM, 4'd4, stall);
    ready_of(2'd1, r); check("ch1_pending_ready", r, 0);
    ready_of(2'd0, r); check("ch0_independent_ready", r, 1);
    wait_strobe();
    ready_of(2'd1, r); check("ch1_ready_after_wrap", r, 1);
    push_win(2, 0, D4, 0, 0);

    // Window 2: ch2 ON, then a second write that must stall until the wrap.
    cfg_write(2'd2, MODE_ON, 4'd0, stall);
    check("ch2_first_no_stall", stall, 0);
    cfg_write(2'd2, MODE_PWM, 4'd8, stall);
    check("ch2_second_stalled", int'(stall > 0), 1);
    push_win(3, 0, D4, 32, 0);

    // Window 3: ch3 BLINK duty 15; blink phase on in windows 6,7 (mod 4 >= 2).
    cfg_write(2'd3, MODE_BLINK, 4'd15, stall);
    check("ch3_no_stall", stall, 0);
    push_win(4,  0, D4, D8,  0);
    push_win(5,  0, D4, D8,  0);
    push_win(6, 32, D4, D8, 30);
    push_win(7, 32, D4, D8, 30);
    push_win(8, 32, D4, D8,  0);

    // Window 4: write ch0 ON exactly on the wrap cycle ending window 4.
    wait_strobe();
    repeat (31) @(posedge clk);
    #1;
    cfg.cfg_ch    = 2'd0;
    cfg.cfg_mode  = MODE_ON;
    cfg.cfg_duty  = 4'd0;
    cfg.cfg_valid = 1'b1;
    #1;
    check("wrap_write_ready", int'(cfg.cfg_ready), 1);
    @(posedge clk);
    #1;
    cfg.cfg_valid = 1'b0;
    check("wrap_write_alignment", int'(period_strobe), 1);
    ready_of(2'd0, r); check("ch0_pending_after_wrap_write", r, 0);

    for (int k = 0; k < 400 && cur_win < 9; k++) @(posedge clk);
    check("reached_window_9", int'(cur_win >= 9), 1);
    @(posedge clk);
    #1;

    // Out-of-range channel on the 3-channel instance.
    cfg3.cfg_ch   = 2'd3;
    cfg3.cfg_mode = MODE_ON;
    cfg3.cfg_duty = 4'd15;
    cfg3.cfg_valid = 1'b1;
    #1;
    check("oob_ready", int'(cfg3.cfg_ready), 1);
    @(posedge clk);
    #1;
    cfg3.cfg_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk);
      #1;
      if (led3 != 3'b000) bad++;
    end
    check("oob_led_unchanged", bad, 0);
    for (int i = 0; i < 3; i++) begin
      cfg3.cfg_ch = 2'(i);
      #1;
      check($sformatf("oob_no_pending_ch%0d", i), int'(cfg3.cfg_ready), 1);
    end

    // Asynchronous reset mid-period with a write still pending.
    @(posedge clk);
    #1;
    cfg_write(2'd1, MODE_OFF, 4'd0, stall);
    ready_of(2'd1, r); check("pre_reset_ch1_pending", r, 0);
    check("pre_reset_led0_on", int'(led[0]), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_led", int'(led), 0);
    check("async_reset_led3", int'(led3), 0);
    check("async_reset_strobe", int'(period_strobe), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ready_of(2'd1, r); check("pending_lost_on_reset", r, 1);
    check("post_reset_led", int'(led), 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
